ara_runtime_ctrl: RTL and testbench
===================================

# ara_runtime_ctrl

Vector-runtime measurement controller placed next to Ara in the SoC. It sequences a 64-bit runtime counter and `NrEvents` 64-bit event counters (e.g. D$ miss, I$ miss, scoreboard full). The measurement window is gated by a software enable, the accelerator request-valid and Ara idle. On each idle-after-activity point it snapshots all counters into buffers. The buffers are read over a zero-wait APB slave.

## Interface
- `NrEvents`, default 3: number of event counters; legal range 1..30.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `acc_req_valid_i`  in  1  vector instruction dispatched to Ara this cycle.
- `ara_idle_i`  in  1  Ara has no instruction in flight.
- `event_i`  in  `NrEvents`  per-cycle event strobes.
- `psel_i`, `penable_i`, `pwrite_i`  in  1 each  APB control.
- `paddr_i`  in  32  APB address; only `[7:0]` is decoded.
- `pwdata_i`  in  32  APB write data.
- `prdata_o`  out  32  APB read data.
- `pready_o`  out  1  constant 1.
- `pslverr_o`  out  1  access error.
- `busy_o`  out  1  high in RUN or DRAIN.

The clock and reset are fixed as above: one clock `clk_i`, reset `rst_ni` asynchronous and active-low.

## Operation
**Register map** (byte offsets):
- 0x00 CTRL, read/write.
  - bit0 EN: software enable.
  - bit1 CLR: write-1 pulse, always reads 0.
- 0x04 STATUS, read-only.
  - bit0: busy.
  - bit1: SNAP_VALID.
  - bit2: PENDING.
- 0x08 / 0x0C: runtime snapshot, low / high word.
- 0x10+8i / 0x14+8i: event i snapshot, low / high word.
- pslverr=1 and prdata=0 for:
  - unmapped offsets;
  - writes to read-only registers (such writes have no effect).

**FSM** (IDLE, RUN, DRAIN):
- IDLE→RUN when EN && `acc_req_valid_i`.
- RUN→IDLE when !EN && `ara_idle_i`.
- RUN→DRAIN when !EN && !`ara_idle_i`.
- DRAIN→RUN when EN.
- DRAIN→IDLE when !EN && `ara_idle_i`.

**Counting:**
- In RUN and DRAIN the runtime counter increments by 1 every cycle.
- Event counter i increments when `event_i[i]` is high.
- In IDLE all counters hold.
- Counters wrap modulo 2^64.

**PENDING flag:**
- Set when !PENDING && `acc_req_valid_i`, in any state and regardless of EN.

**Snapshot condition:** PENDING && `ara_idle_i` && !`acc_req_valid_i`. When it holds:
- Copy all live counters (their current registered values) into the snapshot buffers.
- Clear PENDING.
- Set SNAP_VALID.

**CLR:**
- Zeroes live counters, snapshots, PENDING and SNAP_VALID.
- Leaves EN and the FSM state unchanged.
- Has priority over increment and snapshot in the same cycle.

## Timing
**Reset:**
- All outputs 0 except `pready_o` = 1.
- FSM in IDLE.
- All counters, snapshots and flags 0; EN = 0.

**APB:**
- Setup phase: psel && !penable.
- Access phase: psel && penable; it completes in one cycle.
- Writes take effect at the clock edge ending the access phase.
- `prdata_o` and `pslverr_o` are combinational from `paddr_i` during the access phase, and 0 otherwise.

**Counting latency:**
- Transition to RUN is registered: with EN=1, a valid in cycle t gives RUN at t+1.
- The runtime counter reads 1 after t+1.

**Snapshot latency:**
- Buffers update at the edge ending the condition cycle and are readable the following cycle.
- A read in the same cycle as a snapshot returns the old buffer value.

**Simultaneous events:**
- Valid together with idle: no snapshot; PENDING stays or becomes set.
- EN written to 0 in the same cycle as the IDLE→RUN condition: CTRL's registered EN is used, so the transition occurs.

## Configuration
- `ARA_RUNTIME_EVT_CNT_EN` defined: event counters, snapshots and offsets 0x10+ are implemented.
- Undefined:
  - `event_i` is ignored;
  - no event counter flops are implemented;
  - offsets ≥ 0x10 return pslverr=1 and prdata=0;
  - runtime counting and snapshotting are unchanged.

## Test plan
- Write CTRL=1; pulse valid once at cycle 10; hold idle low until cycle 30, then high → FSM RUN from cycle 11; snapshot taken in cycle 30 with runtime=19; read 0x08=19, 0x0C=0; STATUS=0x2 after EN cleared.
- EN=1; `event_i`=3'b101 for 5 cycles in RUN → event0=5, event1=0, event2=5 after snapshot. With the macro undefined, reads of 0x10 → pslverr=1.
- EN=0 while Ara busy → DRAIN; counting continues until `ara_idle_i`; then IDLE and counter holds.
- Valid and idle asserted together for 3 cycles, then valid drops → no snapshot in those cycles; snapshot in the first cycle after; PENDING cleared.
- CLR written in the same cycle as a snapshot condition → all buffers 0; SNAP_VALID=0.
- Assert `rst_ni` low in RUN mid-count → asynchronous return to IDLE; counters 0; `busy_o`=0. Access to offset 0xF0 → pslverr=1. Write to 0x08 → pslverr=1, value unchanged.

Source files
------------

// File: rtl/ara_runtime_ctrl.sv
// ara_runtime_ctrl: vector-runtime measurement controller beside Ara. It gates a 64-bit
//   runtime counter and NrEvents 64-bit event counters, and snapshots them whenever Ara goes idle after activity.
// Latency: the FSM and counters are registered. Valid at cycle t gives RUN at t+1. Snapshots are readable one cycle after the condition.
// Backpressure: none. The APB slave is zero-wait, so pready_o is tied to 1 and reads decode combinationally in the access phase.
// Ports:
//   clk_i/rst_ni        clock and asynchronous active-low reset
//   acc_req_valid_i     vector instruction dispatched to Ara
//   ara_idle_i          Ara has nothing in flight
//   event_i             per-cycle event strobes
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr   APB slave
//   busy_o              measurement window open (RUN or DRAIN)
// Build option: define ARA_RUNTIME_EVT_CNT_EN to implement the event counters and offsets 0x10+.
module ara_runtime_ctrl #(
  parameter int unsigned NrEvents = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                acc_req_valid_i,
  input  logic                ara_idle_i,
  input  logic [NrEvents-1:0] event_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [31:0]         paddr_i,
  input  logic [31:0]         pwdata_i,
  output logic [31:0]         prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  output logic                busy_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        en_q, en_d;
  logic        pending_q, pending_d;
  logic        snap_valid_q, snap_valid_d;
  logic [63:0] rt_cnt_q, rt_cnt_d;
  logic [63:0] rt_snap_q, rt_snap_d;

  logic        access, ctrl_wr, clr, counting, snap;
  logic [7:0]  addr;
  logic [31:0] rd_data;
  logic        rd_err;

  assign addr     = paddr_i[7:0];
  assign access   = psel_i & penable_i;
  assign ctrl_wr  = access & pwrite_i & (addr == 8'h00);
  assign clr      = ctrl_wr & pwdata_i[1];
  assign counting = (state_q != StIdle);
  // A dispatch in the same cycle as idle means new work, so it suppresses the snapshot.
  assign snap     = pending_q & ara_idle_i & ~acc_req_valid_i;
  assign busy_o   = counting;
  assign pready_o = 1'b1;

  // The FSM looks at the registered EN, so a CTRL write only steers it from the next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en_q && acc_req_valid_i) state_d = StRun;
      StRun:   if (!en_q) state_d = ara_idle_i ? StIdle : StDrain;
      StDrain: begin
        if (en_q)            state_d = StRun;
        else if (ara_idle_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // CLR beats both increment and snapshot. EN and the FSM state are left alone.
  always_comb begin
    en_d         = ctrl_wr ? pwdata_i[0] : en_q;
    rt_cnt_d     = rt_cnt_q;
    rt_snap_d    = rt_snap_q;
    pending_d    = pending_q;
    snap_valid_d = snap_valid_q;
    if (clr) begin
      rt_cnt_d     = '0;
      rt_snap_d    = '0;
      pending_d    = 1'b0;
      snap_valid_d = 1'b0;
    end else begin
      if (counting) rt_cnt_d = rt_cnt_q + 64'd1;
      if (snap) begin
        rt_snap_d    = rt_cnt_q;
        pending_d    = 1'b0;
        snap_valid_d = 1'b1;
      end else if (acc_req_valid_i) begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      en_q         <= 1'b0;
      pending_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      rt_cnt_q     <= '0;
      rt_snap_q    <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      pending_q    <= pending_d;
      snap_valid_q <= snap_valid_d;
      rt_cnt_q     <= rt_cnt_d;
      rt_snap_q    <= rt_snap_d;
    end
  end

`ifdef ARA_RUNTIME_EVT_CNT_EN
  logic [NrEvents-1:0][63:0] evt_cnt_q, evt_cnt_d;
  logic [NrEvents-1:0][63:0] evt_snap_q, evt_snap_d;

  always_comb begin
    evt_cnt_d  = evt_cnt_q;
    evt_snap_d = evt_snap_q;
    for (int i = 0; i < NrEvents; i++) begin
      if (clr) begin
        evt_cnt_d[i]  = '0;
        evt_snap_d[i] = '0;
      end else begin
        if (counting && event_i[i]) evt_cnt_d[i] = evt_cnt_q[i] + 64'd1;
        if (snap) evt_snap_d[i] = evt_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_cnt_q  <= '0;
      evt_snap_q <= '0;
    end else begin
      evt_cnt_q  <= evt_cnt_d;
      evt_snap_q <= evt_snap_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{paddr_i[31:8], pwdata_i[31:2]};
`else
  logic unused_bits;
  assign unused_bits = ^{paddr_i[31:8], pwdata_i[31:2], event_i};
`endif

  // Read decode. Writes to read-only offsets flag an error and are otherwise ignored.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (addr)
      8'h00: rd_data = {31'b0, en_q};
      8'h04: begin
        rd_err  = pwrite_i;
        rd_data = {29'b0, pending_q, snap_valid_q, busy_o};
      end
      8'h08: begin
        rd_err  = pwrite_i;
        rd_data = rt_snap_q[31:0];
      end
      8'h0C: begin
        rd_err  = pwrite_i;
        rd_data = rt_snap_q[63:32];
      end
      default: begin
        rd_err = 1'b1;
`ifdef ARA_RUNTIME_EVT_CNT_EN
        for (int i = 0; i < NrEvents; i++) begin
          if (addr == 8'(16 + 8 * i)) begin
            rd_err  = pwrite_i;
            rd_data = evt_snap_q[i][31:0];
          end
          if (addr == 8'(20 + 8 * i)) begin
            rd_err  = pwrite_i;
            rd_data = evt_snap_q[i][63:32];
          end
        end
`endif
      end
    endcase
  end

  assign prdata_o  = (access && !rd_err) ? rd_data : 32'd0;
  assign pslverr_o = access & rd_err;

endmodule

// File: tb/tb_ara_runtime_ctrl.sv
// Bench for ara_runtime_ctrl. A cycle-level behavioural model predicts busy_o and the APB read data, and one negedge process compares the DUT against it.
// Directed sequences add literal checks on top of the model.
module tb_ara_runtime_ctrl;
  localparam int NE = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          acc_req_valid_i = 1'b0;
  logic          ara_idle_i = 1'b1;
  logic [NE-1:0] event_i = '0;
  logic          psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [31:0]   paddr_i = '0, pwdata_i = '0;
  logic [31:0]   prdata_o;
  logic          pready_o, pslverr_o, busy_o;

  int n_cmp = 0;
  int n_fail = 0;

  ara_runtime_ctrl #(.NrEvents(NE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .acc_req_valid_i(acc_req_valid_i), .ara_idle_i(ara_idle_i),
    .event_i(event_i), .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The window is modelled as one "open" bit. RUN and DRAIN look the same from outside.
  bit              m_open, m_en, m_pend, m_sv;
  longint unsigned m_rt, m_rts;
  longint unsigned m_ev[NE];
  longint unsigned m_evs[NE];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_open <= 0; m_en <= 0; m_pend <= 0; m_sv <= 0; m_rt <= 0; m_rts <= 0;
      for (int i = 0; i < NE; i++) begin m_ev[i] <= 0; m_evs[i] <= 0; end
    end else begin
      bit wr_ctrl, clr, idle_pt;
      wr_ctrl = psel_i && penable_i && pwrite_i && paddr_i[7:0] == 8'h00;
      clr     = wr_ctrl && pwdata_i[1];
      idle_pt = m_pend && ara_idle_i && !acc_req_valid_i;
      // Once open, the window stays open while software wants it or Ara still has work.
      m_open <= m_open ? (m_en || !ara_idle_i) : (m_en && acc_req_valid_i);
      if (wr_ctrl) m_en <= pwdata_i[0];
      if (clr) begin
        m_rt <= 0; m_rts <= 0; m_pend <= 0; m_sv <= 0;
        for (int i = 0; i < NE; i++) begin m_ev[i] <= 0; m_evs[i] <= 0; end
      end else begin
        if (m_open) m_rt <= m_rt + 1;
`ifdef ARA_RUNTIME_EVT_CNT_EN
        for (int i = 0; i < NE; i++) if (m_open && event_i[i]) m_ev[i] <= m_ev[i] + 1;
`endif
        if (idle_pt) begin
          m_rts <= m_rt; m_sv <= 1; m_pend <= 0;
          for (int i = 0; i < NE; i++) m_evs[i] <= m_ev[i];
        end else if (acc_req_valid_i) m_pend <= 1;
      end
    end
  end

  // Returns {error, data} for the given offset.
  function automatic logic [32:0] m_read(input logic [7:0] a, input logic w);
    if (a == 8'h00) return {1'b0, 31'd0, m_en};
    if (a == 8'h04) return w ? 33'h1_0000_0000 : {1'b0, 29'd0, m_pend, m_sv, m_open};
    if (a == 8'h08) return w ? 33'h1_0000_0000 : {1'b0, m_rts[31:0]};
    if (a == 8'h0C) return w ? 33'h1_0000_0000 : {1'b0, m_rts[63:32]};
`ifdef ARA_RUNTIME_EVT_CNT_EN
    for (int i = 0; i < NE; i++) begin
      if (a == 8'(16 + 8 * i)) return w ? 33'h1_0000_0000 : {1'b0, m_evs[i][31:0]};
      if (a == 8'(20 + 8 * i)) return w ? 33'h1_0000_0000 : {1'b0, m_evs[i][63:32]};
    end
`endif
    return 33'h1_0000_0000;
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni) begin
      logic [32:0] e;
      chk("busy_o", busy_o, m_open);
      chk("pready_o", pready_o, 1);
      if (psel_i && penable_i) e = m_read(paddr_i[7:0], pwrite_i);
      else e = '0;
      chk("prdata_o", prdata_o, e[31:0]);
      chk("pslverr_o", pslverr_o, e[32]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] ed, input logic ee, input string nm);
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = {24'd0, a};
    step();
    penable_i = 1;
    @(negedge clk_i);
    chk({nm, ".data"}, prdata_o, ed);
    chk({nm, ".err"}, pslverr_o, ee);
    step();
    psel_i = 0; penable_i = 0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic ee, input string nm);
    psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = {24'd0, a}; pwdata_i = d;
    step();
    penable_i = 1;
    @(negedge clk_i);
    chk({nm, ".err"}, pslverr_o, ee);
    step();
    psel_i = 0; penable_i = 0; pwrite_i = 0;
  endtask

  initial begin
    #2;
    chk("rst.busy", busy_o, 0);
    chk("rst.pready", pready_o, 1);
    chk("rst.prdata", prdata_o, 0);
    chk("rst.pslverr", pslverr_o, 0);
    step(2);
    rst_ni = 1;
    step();
    apb_read(8'h04, 32'h0, 0, "status_after_reset");

    // Runtime window: valid at t, idle from t+20, so the snapshot sees 19.
    apb_write(8'h00, 32'h1, 0, "ctrl_en");
    ara_idle_i = 0; acc_req_valid_i = 1;
    step();
    acc_req_valid_i = 0;
    chk("run_busy", busy_o, 1);
    step(19);
    ara_idle_i = 1;
    step();
    apb_read(8'h08, 32'd19, 0, "rt_lo");
    apb_read(8'h0C, 32'd0, 0, "rt_hi");
    apb_write(8'h00, 32'h0, 0, "ctrl_dis");
    apb_read(8'h04, 32'h2, 0, "status_snap");

    // Event counters.
`ifdef ARA_RUNTIME_EVT_CNT_EN
    apb_write(8'h00, 32'h1, 0, "ctrl_en2");
    ara_idle_i = 0; acc_req_valid_i = 1;
    step();
    acc_req_valid_i = 0; event_i = 3'b101;
    step(5);
    event_i = '0; ara_idle_i = 1;
    step();
    apb_write(8'h00, 32'h0, 0, "ctrl_dis2");
    apb_read(8'h10, 32'd5, 0, "ev0");
    apb_read(8'h18, 32'd0, 0, "ev1");
    apb_read(8'h20, 32'd5, 0, "ev2");
    apb_read(8'h24, 32'd0, 0, "ev2_hi");
`else
    apb_read(8'h10, 32'd0, 1, "ev0_absent");
`endif

    // Drain: EN drops while Ara is busy.
    apb_write(8'h00, 32'h1, 0, "ctrl_en3");
    ara_idle_i = 0; acc_req_valid_i = 1;
    step();
    acc_req_valid_i = 0;
    step(3);
    apb_write(8'h00, 32'h0, 0, "ctrl_dis3");
    step(3);
    chk("drain_busy", busy_o, 1);
    ara_idle_i = 1;
    step();
    chk("drain_done", busy_o, 0);
    step(5);

    // Valid with idle for three cycles: PENDING is set and no snapshot is taken until valid drops.
    acc_req_valid_i = 1;
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 32'h4;
    step();
    penable_i = 1;
    @(negedge clk_i);
    chk("status_pending", prdata_o, 32'h6);
    step();
    psel_i = 0; penable_i = 0;
    step();
    acc_req_valid_i = 0;
    step();
    apb_read(8'h04, 32'h2, 0, "status_pend_clr");
    apb_read(8'h08, m_rts[31:0], 0, "rt_held");
    apb_write(8'h08, 32'hDEAD_BEEF, 1, "wr_ro_08");
    apb_read(8'h08, m_rts[31:0], 0, "rt_unchanged");

    // CLR in the same cycle as a snapshot condition.
    ara_idle_i = 0; acc_req_valid_i = 1;
    step();
    acc_req_valid_i = 0;
    psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = 32'h0; pwdata_i = 32'h2;
    step();
    penable_i = 1; ara_idle_i = 1;
    @(negedge clk_i);
    chk("clr_err", pslverr_o, 0);
    step();
    psel_i = 0; penable_i = 0; pwrite_i = 0;
    apb_read(8'h04, 32'h0, 0, "status_clr");
    apb_read(8'h08, 32'h0, 0, "rt_clr");
    apb_read(8'h0C, 32'h0, 0, "rt_hi_clr");

    // Asynchronous reset in the middle of RUN.
    apb_write(8'h00, 32'h1, 0, "ctrl_en4");
    ara_idle_i = 0; acc_req_valid_i = 1;
    step();
    acc_req_valid_i = 0;
    step(4);
    #2 rst_ni = 0;
    #1 chk("async_rst_busy", busy_o, 0);
    step();
    rst_ni = 1; ara_idle_i = 1;
    step();
    apb_read(8'h00, 32'h0, 0, "ctrl_after_rst");
    apb_read(8'h04, 32'h0, 0, "status_after_rst");
    apb_read(8'hF0, 32'h0, 1, "unmapped_f0");
    apb_write(8'h08, 32'h1234, 1, "wr_ro_08b");
    apb_read(8'h08, 32'h0, 0, "rt_after_rst");
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
